fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: PC register plus IF/ID pipeline register for the 64-bit core.
// Optional alignment/range fault detection is compiled in with FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] HALT_WORD  = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] imem_instruction,
    output logic [63:0] imem_addr,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instruction,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    // A memory smaller than one word could never supply an instruction.
    if (IMEM_BYTES < 4) begin : g_imem_too_small
        $error("IMEM_BYTES must cover at least one instruction word");
    end

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        FAULT  = 2'd2
`endif
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic [63:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_instruction_reg, ifid_instruction_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] fetch_count_reg, fetch_count_next;

`ifdef FETCH_ALIGN_CHECK_EN
    logic bad_fetch;
    // Extra top bit keeps pc+4 near 2^64 from wrapping into a small, legal-looking value.
    assign bad_fetch = (pc_reg[1:0] != 2'b00) ||
                       (({1'b0, pc_reg} + 65'd4) > 65'(IMEM_BYTES));
`endif

    always_comb begin
        state_next            = state_reg;
        pc_next               = pc_reg;
        ifid_pc_next          = ifid_pc_reg;
        ifid_instruction_next = ifid_instruction_reg;
        ifid_valid_next       = ifid_valid_reg;
        fetch_count_next      = fetch_count_reg;

`ifdef FETCH_ALIGN_CHECK_EN
        if (state_reg == FAULT) begin
            ifid_valid_next = 1'b0;
        end else
`endif
        if (branch_taken) begin
            // Redirect squashes whatever was fetched from the wrong path.
            pc_next         = branch_target;
            ifid_valid_next = 1'b0;
            state_next      = RUN;
        end else if (state_reg == HALTED) begin
            ifid_valid_next = 1'b0;
        end else if (stall) begin
            ifid_valid_next = ifid_valid_reg;
`ifdef FETCH_ALIGN_CHECK_EN
        end else if (bad_fetch) begin
            ifid_valid_next = 1'b0;
            state_next      = FAULT;
`endif
        end else if (imem_instruction == HALT_WORD) begin
            ifid_valid_next = 1'b0;
            state_next      = HALTED;
        end else begin
            ifid_pc_next          = pc_reg;
            ifid_instruction_next = imem_instruction;
            ifid_valid_next       = 1'b1;
            pc_next               = pc_reg + 64'd4;
            fetch_count_next      = fetch_count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= RUN;
            pc_reg               <= RESET_PC;
            ifid_pc_reg          <= 64'h0;
            ifid_instruction_reg <= 32'h0;
            ifid_valid_reg       <= 1'b0;
            fetch_count_reg      <= 32'h0;
        end else begin
            state_reg            <= state_next;
            pc_reg               <= pc_next;
            ifid_pc_reg          <= ifid_pc_next;
            ifid_instruction_reg <= ifid_instruction_next;
            ifid_valid_reg       <= ifid_valid_next;
            fetch_count_reg      <= fetch_count_next;
        end
    end

    assign imem_addr        = pc_reg;
    assign ifid_pc          = ifid_pc_reg;
    assign ifid_instruction = ifid_instruction_reg;
    assign ifid_valid       = ifid_valid_reg;
    assign halted           = (state_reg == HALTED);
    assign fetch_count      = fetch_count_reg;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault      = (state_reg == FAULT);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, scoreboard-checked bench for fetch_stage (default build, alignment check disabled).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] imem_instruction;
    logic [63:0] imem_addr;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instruction;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int tests    = 0;
    int failures = 0;

    logic [31:0] mem [16];

    typedef struct {
        string       tag;
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [31:0] instr;
        logic        v;
        logic        h;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_instruction (imem_instruction),
        .imem_addr        (imem_addr),
        .ifid_pc          (ifid_pc),
        .ifid_instruction (ifid_instruction),
        .ifid_valid       (ifid_valid),
        .halted           (halted),
        .fetch_count      (fetch_count)
    );

    always #5 clk = ~clk;

    // Unmapped addresses read as zero, like unused memory.
    always_comb begin
        imem_instruction = 32'h0;
        if (imem_addr < 64'd64) imem_instruction = mem[imem_addr[5:2]];
    end

    task automatic chk(input string tag, input string field, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failures++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        chk(e.tag, "pc",    imem_addr,                 e.pc);
        chk(e.tag, "ifid_pc", ifid_pc,                 e.ipc);
        chk(e.tag, "instr", {32'h0, ifid_instruction}, {32'h0, e.instr});
        chk(e.tag, "valid", {63'h0, ifid_valid},       {63'h0, e.v});
        chk(e.tag, "halted", {63'h0, halted},          {63'h0, e.h});
        chk(e.tag, "count", {32'h0, fetch_count},      {32'h0, e.cnt});
        $display("[TB] %s pc=%h ifid_pc=%h instr=%h v=%0b h=%0b cnt=%0d",
                 e.tag, imem_addr, ifid_pc, ifid_instruction, ifid_valid, halted, fetch_count);
    endtask

    task automatic step(input string tag, input logic rst, input logic st, input logic br,
                        input logic [63:0] tgt, input logic [63:0] e_pc, input logic [63:0] e_ipc,
                        input logic [31:0] e_instr, input logic e_v, input logic e_h,
                        input logic [31:0] e_cnt);
        exp_t e;
        reset         = rst;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        e.tag = tag; e.pc = e_pc; e.ipc = e_ipc; e.instr = e_instr;
        e.v = e_v; e.h = e_h; e.cnt = e_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [31:0] cnt;
        logic [63:0] prev_ipc;
        logic [31:0] prev_instr;
        logic [63:0] a;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'h8B02_0020;   // 0x00
        mem[1]  = 32'h9100_0421;   // 0x04
        mem[4]  = 32'hD100_0842;   // 0x10
        mem[8]  = 32'hAA01_03E3;   // 0x20
        mem[9]  = 32'hCB02_0064;   // 0x24
        mem[11] = 32'h8B01_0000;   // 0x2C
        mem[12] = 32'h9100_1000;   // 0x30
        mem[13] = 32'hCB03_0020;   // 0x34
        mem[14] = 32'hAA02_0041;   // 0x38

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;

        //    tag            rst st  br  tgt     pc      ifid_pc instr          v  h  cnt
        step("reset",        1, 0, 0, 64'h0,  64'h0,  64'h0,  32'h0,         0, 0, 0);
        step("fetch0",       0, 0, 0, 64'h0,  64'h4,  64'h0,  32'h8B02_0020, 1, 0, 1);
        step("fetch4",       0, 0, 0, 64'h0,  64'h8,  64'h4,  32'h9100_0421, 1, 0, 2);
        step("halt8",        0, 0, 0, 64'h0,  64'h8,  64'h4,  32'h9100_0421, 0, 1, 2);
        step("halt_stall",   0, 1, 0, 64'h0,  64'h8,  64'h4,  32'h9100_0421, 0, 1, 2);
        step("br_from_halt", 0, 0, 1, 64'h0,  64'h0,  64'h4,  32'h9100_0421, 0, 0, 2);
        step("refetch0",     0, 0, 0, 64'h0,  64'h4,  64'h0,  32'h8B02_0020, 1, 0, 3);
        step("refetch4",     0, 0, 0, 64'h0,  64'h8,  64'h4,  32'h9100_0421, 1, 0, 4);
        step("stall1",       0, 1, 0, 64'h0,  64'h8,  64'h4,  32'h9100_0421, 1, 0, 4);
        step("stall2",       0, 1, 0, 64'h0,  64'h8,  64'h4,  32'h9100_0421, 1, 0, 4);
        step("stall3",       0, 1, 0, 64'h0,  64'h8,  64'h4,  32'h9100_0421, 1, 0, 4);
        step("br_in_stall",  0, 1, 1, 64'h20, 64'h20, 64'h4,  32'h9100_0421, 0, 0, 4);
        step("tgt20",        0, 0, 0, 64'h0,  64'h24, 64'h20, 32'hAA01_03E3, 1, 0, 5);
        step("stall24",      0, 1, 0, 64'h0,  64'h24, 64'h20, 32'hAA01_03E3, 1, 0, 5);
        step("resume24",     0, 0, 0, 64'h0,  64'h28, 64'h24, 32'hCB02_0064, 1, 0, 6);
        step("halt28",       0, 0, 0, 64'h0,  64'h28, 64'h24, 32'hCB02_0064, 0, 1, 6);
        step("br10",         0, 0, 1, 64'h10, 64'h10, 64'h24, 32'hCB02_0064, 0, 0, 6);
        step("fetch10",      0, 0, 0, 64'h0,  64'h14, 64'h10, 32'hD100_0842, 1, 0, 7);
        step("halt14",       0, 0, 0, 64'h0,  64'h14, 64'h10, 32'hD100_0842, 0, 1, 7);

        // Two passes over 0x2C..0x38 bring fetch_count to 15 halted at 0x3C.
        cnt = 32'd7; prev_ipc = 64'h10; prev_instr = 32'hD100_0842;
        for (int k = 0; k < 2; k++) begin
            step("br2c", 0, 0, 1, 64'h2C, 64'h2C, prev_ipc, prev_instr, 0, 0, cnt);
            for (int i = 0; i < 4; i++) begin
                a = 64'h2C + 64'(4 * i);
                cnt = cnt + 32'd1;
                step("run2c", 0, 0, 0, 64'h0, a + 64'd4, a, mem[a[5:2]], 1, 0, cnt);
            end
            step("halt3c", 0, 0, 0, 64'h0, 64'h3C, 64'h38, 32'hAA02_0041, 0, 1, cnt);
            prev_ipc = 64'h38; prev_instr = 32'hAA02_0041;
        end

        step("reset_halted", 1, 1, 1, 64'h50, 64'h0, 64'h0, 32'h0,         0, 0, 0);
        step("post_reset",   0, 0, 0, 64'h0,  64'h4, 64'h0, 32'h8B02_0020, 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
